alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised, clocked successor to the combinational datapath ALU.
- Adds configurable width, a valid/ready handshake on both sides, registered results with zero/carry flags, and two multi-cycle operations: iterative multiply and variable logical shift right.
- Sits between register-file read and writeback; the control FSM stalls on in_ready/out_valid instead of assuming a single-cycle result.

Parameters:
- WIDTH, 16, operand/result width in bits (>=4, power of two).
- SHW, $clog2(WIDTH), shift-amount width (derived localparam, not overridable).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands/op presented
- in_ready  out  1  block can accept an op this cycle
- op  in  3  operation select
- x  in  WIDTH  operand X
- y  in  WIDTH  operand Y
- out_valid  out  1  result/flags valid
- out_ready  in  1  consumer takes result this cycle
- z  out  WIDTH  result
- zero  out  1  z == 0
- carry  out  1  carry-out of ADD; 0 for all other ops

Behaviour:
- Reset: asynchronous assert, synchronous release; acts immediately.
  - State IDLE; z=0, zero=0, carry=0, out_valid=0.
  - Internal accumulator/counter cleared.
  - in_ready=0 while rst_n low, then 1 from the first clock edge after release.
  - Reset mid-operation aborts the op with no output.
- Op encoding: 0 ADD (x+y, carry=bit WIDTH); 1 AND; 2 OR; 3 XOR; 4 ANY (z=(x!=0), zero-extended); 5 SHR1 (x>>1, logical); 6 MUL (low WIDTH bits of x*y, unsigned); 7 SHRN (x >> y[SHW-1:0], logical). All arithmetic wraps modulo 2^WIDTH.
- Handshake: transfer in on in_valid&&in_ready; transfer out on out_valid&&out_ready. op/x/y are sampled only at in-transfer; later changes are ignored.
- States:
  - IDLE: in_ready=1. On accept of ops 0-5, or SHRN with amount 0 -> DONE, result registered at that edge (latency 1). On accept of MUL -> BUSY, count=WIDTH. On accept of SHRN with amount k>0 -> BUSY, count=k.
  - BUSY: in_ready=0, out_valid=0. MUL does one shift-add step per cycle (LSB of multiplier first). SHRN shifts right one bit per cycle. Count decrements each cycle; when count reaches 0, the result is registered and state -> DONE.
  - DONE: out_valid=1 and z/zero/carry held stable until out_ready.
    - out_ready=1 and in_valid=0 -> IDLE, out_valid falls next cycle.
    - out_ready=1 and in_valid=1: in_ready=1 combinationally; the new op is accepted in the same cycle (back-to-back). Next state follows the IDLE rules.
    - out_ready=0 -> stay, in_ready=0.
- Latency, accept at edge t: single-cycle ops valid after edge t+1; MUL after t+1+WIDTH; SHRN k>0 after t+1+k. The out_valid=1 cycle in each case counts as the first DONE cycle.
- Throughput: one single-cycle op per clock when out_ready is held high.
- zero is computed from the final registered z for every op.
- SHRN with amount >= WIDTH cannot occur, since only SHW bits are used (e.g. y=16 with WIDTH=16 gives amount 0).
- No op is dropped or duplicated. in_valid while in_ready=0 is held by the producer; no internal queue.

Test Plan:
- Reset: hold rst_n=0 with in_valid=1 -> in_ready=0, out_valid=0, z=0. Assert rst_n=0 during the 5th cycle of MUL -> out_valid stays 0. After release, IDLE with in_ready=1.
- ADD carry/zero, WIDTH=16: x=16'hFFFF, y=16'h0001 -> z=0, zero=1, carry=1, one cycle after accept. x=3, y=4 -> z=7, zero=0, carry=0.
- Back-to-back stream: AND, OR, XOR, ANY(x=0), SHR1(x=16'h8001) with out_ready=1 continuous -> five results on five consecutive cycles: x&y, x|y, x^y, 0 with zero=1, 16'h4000.
- MUL: x=16'h0123, y=16'h0011 -> z=16'h1353 exactly 17 cycles after accept, in_ready=0 meanwhile. x=16'hFFFF, y=16'hFFFF -> z=16'h0001.
- SHRN: x=16'hF000, y=4 -> z=16'h0F00 after 5 cycles. y=0 -> z=x after 1 cycle. y=16'h0013 -> amount 3, z=16'h1E00.
- Backpressure: complete ADD, hold out_ready=0 for 10 cycles while toggling x/y/op -> z/zero/carry stable, in_ready=0. Release out_ready with in_valid=1 -> next op accepted that same cycle.

Source files
------------

// File: rtl/alu_seq.sv
// Clocked ALU with valid/ready handshakes, registered z/zero/carry results,
// and two multi-cycle ops: iterative shift-add multiply and variable logical shift right.
module alu_seq #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] z,
  output logic             zero,
  output logic             carry
);

  localparam int unsigned SHW  = $clog2(WIDTH);
  localparam int unsigned CntW = SHW + 1;

  localparam logic [2:0] OpAdd  = 3'd0;
  localparam logic [2:0] OpAnd  = 3'd1;
  localparam logic [2:0] OpOr   = 3'd2;
  localparam logic [2:0] OpXor  = 3'd3;
  localparam logic [2:0] OpAny  = 3'd4;
  localparam logic [2:0] OpShr1 = 3'd5;
  localparam logic [2:0] OpMul  = 3'd6;
  localparam logic [2:0] OpShrn = 3'd7;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e            state_q;
  logic              rst_done_q;
  logic [WIDTH-1:0]  z_q;
  logic              zero_q;
  logic              carry_q;
  logic [WIDTH-1:0]  acc_q;
  logic [WIDTH-1:0]  mcand_q;
  logic [WIDTH-1:0]  mplier_q;
  logic [CntW-1:0]   count_q;
  logic              is_mul_q;

  logic              accept;
  logic [SHW-1:0]    shamt;
  logic [WIDTH:0]    add_full;
  logic [WIDTH-1:0]  single_z;
  logic [WIDTH-1:0]  step_z;

  // rst_done_q keeps in_ready low until the first edge after reset release.
  assign in_ready  = rst_done_q &&
                     ((state_q == StIdle) || ((state_q == StDone) && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == StDone);
  assign z         = z_q;
  assign zero      = zero_q;
  assign carry     = carry_q;
  assign shamt     = y[SHW-1:0];

  always_comb begin
    add_full = {1'b0, x} + {1'b0, y};
    single_z = '0;
    unique case (op)
      OpAdd:  single_z = add_full[WIDTH-1:0];
      OpAnd:  single_z = x & y;
      OpOr:   single_z = x | y;
      OpXor:  single_z = x ^ y;
      OpAny:  single_z = {{(WIDTH-1){1'b0}}, |x};
      OpShr1: single_z = {1'b0, x[WIDTH-1:1]};
      OpShrn: single_z = x;  // only reached with a zero shift amount
      default: single_z = '0;
    endcase
  end

  // One iteration of the active multi-cycle op; the multiplier is consumed LSB first.
  always_comb begin
    step_z = '0;
    if (is_mul_q) begin
      step_z = acc_q + (mplier_q[0] ? mcand_q : '0);
    end else begin
      step_z = {1'b0, acc_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      rst_done_q <= 1'b0;
      z_q        <= '0;
      zero_q     <= 1'b0;
      carry_q    <= 1'b0;
      acc_q      <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      count_q    <= '0;
      is_mul_q   <= 1'b0;
    end else begin
      rst_done_q <= 1'b1;
      unique case (state_q)
        StIdle, StDone: begin
          if (accept) begin
            if (op == OpMul) begin
              state_q  <= StBusy;
              is_mul_q <= 1'b1;
              acc_q    <= '0;
              mcand_q  <= x;
              mplier_q <= y;
              count_q  <= CntW'(WIDTH);
            end else if ((op == OpShrn) && (shamt != '0)) begin
              state_q  <= StBusy;
              is_mul_q <= 1'b0;
              acc_q    <= x;
              count_q  <= CntW'(shamt);
            end else begin
              state_q <= StDone;
              z_q     <= single_z;
              zero_q  <= (single_z == '0);
              carry_q <= (op == OpAdd) ? add_full[WIDTH] : 1'b0;
            end
          end else if ((state_q == StDone) && out_ready) begin
            state_q <= StIdle;
          end
        end
        StBusy: begin
          acc_q    <= step_z;
          mcand_q  <= {mcand_q[WIDTH-2:0], 1'b0};
          mplier_q <= {1'b0, mplier_q[WIDTH-1:1]};
          count_q  <= count_q - CntW'(1);
          if (count_q == CntW'(1)) begin
            state_q <= StDone;
            z_q     <= step_z;
            zero_q  <= (step_z == '0);
            carry_q <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: a scoreboard queue holds expected results,
// popped and checked whenever an output transfer happens.
module tb_alu_seq;

  localparam int unsigned W = 16;

  typedef struct packed {
    logic [W-1:0] z;
    logic         zero;
    logic         carry;
  } res_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   op;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] z;
  logic         zero;
  logic         carry;

  res_t exp_q[$];
  res_t mon_e;
  int   checks = 0;
  int   errors = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .x         (x),
    .y         (y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .z         (z),
    .zero      (zero),
    .carry     (carry)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Independent reference for the random tail.
  function automatic res_t model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    res_t r;
    logic [W:0]     s;
    logic [2*W-1:0] p;
    s = {1'b0, a} + {1'b0, b};
    p = a * b;
    r.carry = 1'b0;
    case (o)
      3'd0: begin r.z = s[W-1:0]; r.carry = s[W]; end
      3'd1: r.z = a & b;
      3'd2: r.z = a | b;
      3'd3: r.z = a ^ b;
      3'd4: r.z = (a != 0) ? W'(1) : W'(0);
      3'd5: r.z = a >> 1;
      3'd6: r.z = p[W-1:0];
      default: r.z = a >> b[3:0];
    endcase
    r.zero = (r.z == 0);
    return r;
  endfunction

  // Output monitor: sampled on the falling edge, transfer happens at the next rising edge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL unexpected_output: observed z=%h expected no output", z);
      end else begin
        mon_e = exp_q.pop_front();
        check("result_z", 32'(z), 32'(mon_e.z));
        check("result_zero", 32'(zero), 32'(mon_e.zero));
        check("result_carry", 32'(carry), 32'(mon_e.carry));
      end
    end
  end

  // Drives one op, waits for its accept, then optionally measures latency to out_valid.
  task automatic send(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                      input res_t e, input bit push, input int lat);
    int n;
    bit got;
    @(posedge clk);
    #1;
    op = o; x = a; y = b; in_valid = 1'b1;
    if (push) exp_q.push_back(e);
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      got = in_ready;
    end
    check("accept_ready", 32'(got), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op = 3'($urandom); x = W'($urandom); y = W'($urandom);
    if (lat > 0) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
        if (!out_valid) check("busy_in_ready", 32'(in_ready), 32'd0);
      end while (!out_valid && n < 100);
      check("latency", n, lat);
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end

  initial begin
    res_t e;
    logic [2:0]   ro;
    logic [W-1:0] ra, rb;
    logic [2:0]   s_op [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
    logic [W-1:0] s_x  [5] = '{16'hF0F0, 16'hF0F0, 16'hF0F0, 16'h0000, 16'h8001};
    logic [W-1:0] s_y  [5] = '{16'h3C3C, 16'h3C3C, 16'h3C3C, 16'h1234, 16'h0000};
    res_t         s_e  [5] = '{'{16'h3030, 1'b0, 1'b0}, '{16'hFCFC, 1'b0, 1'b0},
                               '{16'hCCCC, 1'b0, 1'b0}, '{16'h0000, 1'b1, 1'b0},
                               '{16'h4000, 1'b0, 1'b0}};

    // Reset with a pending request.
    rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1; op = 3'd6; x = 16'h1111; y = 16'h2222;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_z", 32'(z), 32'd0);
    check("rst_zero", 32'(zero), 32'd0);
    check("rst_carry", 32'(carry), 32'd0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    check("release_in_ready_pre_edge", 32'(in_ready), 32'd0);
    @(negedge clk);
    check("release_in_ready", 32'(in_ready), 32'd1);
    check("release_out_valid", 32'(out_valid), 32'd0);

    // ADD carry/zero.
    send(3'd0, 16'hFFFF, 16'h0001, '{16'h0000, 1'b1, 1'b1}, 1'b1, 1);
    send(3'd0, 16'h0003, 16'h0004, '{16'h0007, 1'b0, 1'b0}, 1'b1, 1);

    // Back-to-back single-cycle stream.
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      op = s_op[i]; x = s_x[i]; y = s_y[i]; in_valid = 1'b1;
      exp_q.push_back(s_e[i]);
      @(negedge clk);
      check("stream_in_ready", 32'(in_ready), 32'd1);
      if (i > 0) check("stream_out_valid", 32'(out_valid), 32'd1);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("stream_last_valid", 32'(out_valid), 32'd1);
    @(negedge clk);
    check("stream_drained", 32'(out_valid), 32'd0);

    // Multiply.
    send(3'd6, 16'h0123, 16'h0011, '{16'h1353, 1'b0, 1'b0}, 1'b1, 17);
    send(3'd6, 16'hFFFF, 16'hFFFF, '{16'h0001, 1'b0, 1'b0}, 1'b1, 17);
    send(3'd6, 16'h0000, 16'h1234, '{16'h0000, 1'b1, 1'b0}, 1'b1, 17);

    // Variable shift.
    send(3'd7, 16'hF000, 16'h0004, '{16'h0F00, 1'b0, 1'b0}, 1'b1, 5);
    send(3'd7, 16'hF000, 16'h0000, '{16'hF000, 1'b0, 1'b0}, 1'b1, 1);
    send(3'd7, 16'hF000, 16'h0013, '{16'h1E00, 1'b0, 1'b0}, 1'b1, 4);
    send(3'd7, 16'h8000, 16'h000F, '{16'h0001, 1'b0, 1'b0}, 1'b1, 16);
    send(3'd7, 16'h8000, 16'h0010, '{16'h8000, 1'b0, 1'b0}, 1'b1, 1);

    // Reset in the 5th cycle of a multiply aborts it silently.
    e = '{16'h0, 1'b0, 1'b0};
    send(3'd6, 16'h0005, 16'h0005, e, 1'b0, 0);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_release_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("abort_no_output", 32'(out_valid), 32'd0);
    end

    // Backpressure: result held, then released together with a new accept.
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    op = 3'd0; x = 16'hFFFF; y = 16'h0002; in_valid = 1'b1;
    exp_q.push_back('{16'h0001, 1'b0, 1'b1});
    @(negedge clk);
    check("bp_accept", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      op = 3'($urandom); x = W'($urandom); y = W'($urandom);
      @(negedge clk);
      check("bp_z", 32'(z), 32'h0001);
      check("bp_flags", 32'({out_valid, zero, carry}), 32'b101);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    op = 3'd3; x = 16'h00FF; y = 16'h0F0F; in_valid = 1'b1;
    exp_q.push_back('{16'h0FF0, 1'b0, 1'b0});
    @(negedge clk);
    check("bp_hold_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("bp_next_valid", 32'(out_valid), 32'd1);

    // Random tail against the reference model.
    for (int i = 0; i < 12; i++) begin
      ro = 3'($urandom); ra = W'($urandom); rb = W'($urandom);
      if (i % 4 == 0) ra = '0;
      send(ro, ra, rb, model(ro, ra, rb), 1'b1,
           (ro == 3'd6) ? 17 : ((ro == 3'd7 && rb[3:0] != 0) ? 1 + int'(rb[3:0]) : 1));
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
